// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding selects.
// 1-cycle ID->EX latency; a load-use pair asserts stall for one cycle and loads a bubble; flush overrides stall.
module id_ex_hazard_reg #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       rs_data;
        logic [31:0]       rt_data;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic              mem_read;
        logic              reg_write;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             haz;

    always_comb begin
        haz = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
              ((ex_q.rd == id_rs) | (id_uses_rt & (ex_q.rd == id_rt)));
    end

    // Flush discards the ID instruction, so holding IF/ID for it would be pointless.
    assign stall = haz & ~flush;

    always_comb begin
        ex_d = '0;
        if (!(flush | haz)) begin
            ex_d.valid     = id_valid;
            ex_d.pc        = id_pc;
            ex_d.rs_data   = id_rs_data;
            ex_d.rt_data   = id_rt_data;
            ex_d.imm       = id_imm;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.rd        = id_rd;
            ex_d.mem_read  = id_mem_read & id_valid;
            ex_d.reg_write = id_reg_write & id_valid;
            ex_d.ctrl      = id_ctrl;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    // EX/MEM is checked first: it holds the newer value of the register.
    function automatic logic [1:0] fwd_sel(input logic vld, input logic [4:0] src,
                                           input logic em_we, input logic [4:0] em_rd,
                                           input logic mw_we, input logic [4:0] mw_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (vld) begin
            if (em_we && (em_rd != 5'd0) && (em_rd == src)) begin
                sel = 2'b10;
            end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign fwd_a_sel = fwd_sel(ex_q.valid, ex_q.rs, exmem_reg_write, exmem_rd,
                               memwb_reg_write, memwb_rd);
    assign fwd_b_sel = fwd_sel(ex_q.valid, ex_q.rt, exmem_reg_write, exmem_rd,
                               memwb_reg_write, memwb_rd);

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs_data   = ex_q.rs_data;
    assign ex_rt_data   = ex_q.rt_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_rd        = ex_q.rd;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_ctrl      = ex_q.ctrl;
    assign stall_count  = cnt_q;

endmodule
